// File: rtl/operand_reg_file.sv
// operand_reg_file: 32x32 operand register file feeding ALU src1/src2, written back from the ALU result.
// Latency: reads are combinational (0 cycles); writes land on the next rising edge (1 cycle).
// Backpressure: none; every write presented with RegWrite_i=1 and rst_i=0 commits on that edge.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset (regs -> 0, reg[SP_IDX] -> SP_INIT, counter -> 0)
//   RSaddr_i    read port A index  -> RSdata_o (ALU src1)
//   RTaddr_i    read port B index  -> RTdata_o (ALU src2)
//   RDaddr_i    write index
//   RDdata_i    write data, stored unmodified
//   RegWrite_i  write enable
//   wr_cnt_o    saturating count of committed writes to nonzero indices (registered)
//
// Build option: define OPERAND_REG_FILE_BYPASS_EN to forward RDdata_i onto a read port whose
// index matches an in-flight write in the same cycle. Without it, reads show stored state only.

module operand_reg_file #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int SP_IDX  = 29,
  parameter int SP_INIT = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [DATA_W-1:0] RDdata_i,
  input  logic              RegWrite_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic [15:0]       wr_cnt_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [15:0]       wr_cnt_q;
  logic [15:0]       wr_cnt_d;
  logic              wr_commit;

  // Writes to index 0 are dropped entirely: no storage update and no count.
  assign wr_commit = !rst_i && RegWrite_i && (RDaddr_i != '0);

  // Counter saturates at all-ones instead of wrapping.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_commit && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
      end
      wr_cnt_q <= '0;
    end else begin
      if (wr_commit) begin
        regs_q[RDaddr_i] <= RDdata_i;
      end
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Index 0 is forced to zero at the read mux as well, so it reads 0 even if
  // the storage location were ever disturbed.
  logic [DATA_W-1:0] rs_stored;
  logic [DATA_W-1:0] rt_stored;

  assign rs_stored = (RSaddr_i == '0) ? '0 : regs_q[RSaddr_i];
  assign rt_stored = (RTaddr_i == '0) ? '0 : regs_q[RTaddr_i];

`ifdef OPERAND_REG_FILE_BYPASS_EN
  // wr_commit already excludes reset and index 0, so forwarding inherits both rules.
  assign RSdata_o = (wr_commit && (RSaddr_i == RDaddr_i)) ? RDdata_i : rs_stored;
  assign RTdata_o = (wr_commit && (RTaddr_i == RDaddr_i)) ? RDdata_i : rt_stored;
`else
  assign RSdata_o = rs_stored;
  assign RTdata_o = rt_stored;
`endif

  assign wr_cnt_o = wr_cnt_q;

endmodule
